// File: rtl/capi_put_req_arb.sv
`default_nettype none
// ============================================================================
// Module   : capi_put_req_arb
// Purpose  : Round-robin arbiter sharing one put-command encoder among NREQ
//            write streams, with per-burst command tag allocation.
// Revision : 1.0
// ============================================================================
module capi_put_req_arb #(
    parameter int EA_WIDTH  = 65,
    parameter int SID_WIDTH = 2,
    parameter int NREQ      = 4,
    parameter int TAG_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREQ-1:0]               i_req_v,
    input  logic [NREQ*EA_WIDTH-1:0]      i_req_ea,
    input  logic [NREQ*SID_WIDTH-1:0]     i_req_sid,
    input  logic [NREQ-1:0]               i_req_data_v,
    input  logic [NREQ-1:0]               i_req_data_e,
    input  logic [NREQ*4-1:0]             i_req_data_c,
    output logic [NREQ-1:0]               o_req_data_r,
    output logic [NREQ-1:0]               o_req_done,
    output logic                          o_addr_v,
    output logic [EA_WIDTH-1:0]           o_addr_ea,
    output logic                          o_data_v,
    output logic                          o_data_e,
    output logic [3:0]                    o_data_c,
    output logic [TAG_WIDTH-1:0]          o_cmd_tag,
    output logic [SID_WIDTH-1:0]          o_sid,
    input  logic                          i_data_r,
    input  logic                          i_rsp_v,
    input  logic [TAG_WIDTH-1:0]          i_rsp_tag,
    output logic [TAG_WIDTH:0]            o_tags_free,
    output logic                          o_tag_err
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NTAGS = 1 << TAG_WIDTH;

    localparam logic [TAG_WIDTH:0] c_ALL_FREE = (TAG_WIDTH+1)'(NTAGS);
    localparam logic [TAG_WIDTH:0] c_ONE      = (TAG_WIDTH+1)'(1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_XFER = 1'b1;

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [IDX_W-1:0]     r_grant;
    logic [IDX_W-1:0]     r_rr;
    logic [TAG_WIDTH-1:0] r_tag;
    logic [EA_WIDTH-1:0]  r_ea;
    logic [SID_WIDTH-1:0] r_sid;
    logic                 r_addr_pend;
    logic [NTAGS-1:0]     r_busy;
    logic [TAG_WIDTH:0]   r_tags_free;
    logic                 r_tag_err;

    logic [EA_WIDTH-1:0]  w_ea_arr  [NREQ];
    logic [SID_WIDTH-1:0] w_sid_arr [NREQ];
    logic [3:0]           w_c_arr   [NREQ];

    logic                 w_pick_v;
    logic [IDX_W-1:0]     w_pick_idx;
    logic [TAG_WIDTH-1:0] w_tag_idx;
    logic                 w_grant_go;
    logic                 w_xfer;
    logic                 w_sel_v;
    logic                 w_sel_e;
    logic                 w_beat_acc;
    logic                 w_end_acc;
    logic                 w_rsp_ok;

    // Requester 0 occupies the most-significant slice of each packed bus.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_ea_arr[gi]  = i_req_ea[(NREQ-1-gi)*EA_WIDTH +: EA_WIDTH];
        assign w_sid_arr[gi] = i_req_sid[(NREQ-1-gi)*SID_WIDTH +: SID_WIDTH];
        assign w_c_arr[gi]   = i_req_data_c[(NREQ-1-gi)*4 +: 4];
    end

    function automatic logic [IDX_W-1:0] f_wrap(input int v);
        return (v >= NREQ) ? IDX_W'(v - NREQ) : IDX_W'(v);
    endfunction

    // Scan downward so the candidate closest to the rr pointer wins.
    always_comb begin
        w_pick_v   = 1'b0;
        w_pick_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req_v[f_wrap(int'(r_rr) + k)]) begin
                w_pick_v   = 1'b1;
                w_pick_idx = f_wrap(int'(r_rr) + k);
            end
        end
    end

    always_comb begin
        w_tag_idx = '0;
        for (int t = NTAGS - 1; t >= 0; t--) begin
            if (!r_busy[t]) begin
                w_tag_idx = TAG_WIDTH'(t);
            end
        end
    end

    assign w_xfer     = (r_state == S_XFER);
    assign w_grant_go = (r_state == S_IDLE) && w_pick_v && (r_tags_free != '0);
    assign w_sel_v    = w_xfer & i_req_data_v[r_grant];
    assign w_sel_e    = w_xfer & i_req_data_e[r_grant];
    assign w_beat_acc = w_sel_v & i_data_r;
    assign w_end_acc  = w_beat_acc & w_sel_e;
    assign w_rsp_ok   = i_rsp_v & r_busy[i_rsp_tag];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_go) w_state_nxt = S_XFER;
            S_XFER:  if (w_end_acc)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_addr_v     = w_xfer & r_addr_pend;
        o_data_v     = w_sel_v;
        o_data_e     = w_sel_e;
        o_data_c     = w_xfer ? w_c_arr[r_grant] : 4'd0;
        o_req_data_r = '0;
        o_req_done   = '0;
        if (w_xfer) begin
            o_req_data_r[r_grant] = i_data_r;
            o_req_done[r_grant]   = w_end_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant     <= '0;
            r_rr        <= '0;
            r_tag       <= '0;
            r_ea        <= '0;
            r_sid       <= '0;
            r_addr_pend <= 1'b0;
        end else begin
            if (w_grant_go) begin
                r_grant     <= w_pick_idx;
                r_tag       <= w_tag_idx;
                r_ea        <= w_ea_arr[w_pick_idx];
                r_sid       <= w_sid_arr[w_pick_idx];
                r_addr_pend <= 1'b1;
            end else if (w_beat_acc) begin
                r_addr_pend <= 1'b0;
            end
            if (w_end_acc) begin
                r_rr <= (r_grant == IDX_W'(NREQ - 1)) ? '0 : r_grant + IDX_W'(1);
            end
        end
    end

    // A same-cycle free is applied first so the allocation bit always lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy      <= '0;
            r_tags_free <= c_ALL_FREE;
            r_tag_err   <= 1'b0;
        end else begin
            if (w_rsp_ok) begin
                r_busy[i_rsp_tag] <= 1'b0;
            end
            if (w_grant_go) begin
                r_busy[w_tag_idx] <= 1'b1;
            end
            if (i_rsp_v && !r_busy[i_rsp_tag]) begin
                r_tag_err <= 1'b1;
            end
            if (w_grant_go && !w_rsp_ok) begin
                r_tags_free <= r_tags_free - c_ONE;
            end else if (!w_grant_go && w_rsp_ok) begin
                r_tags_free <= r_tags_free + c_ONE;
            end
        end
    end

    assign o_addr_ea   = r_ea;
    assign o_cmd_tag   = r_tag;
    assign o_sid       = r_sid;
    assign o_tags_free = r_tags_free;
    assign o_tag_err   = r_tag_err;

endmodule
`default_nettype wire

// File: tb/tb_capi_put_req_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_capi_put_req_arb
// Purpose  : Randomized self-checking bench for capi_put_req_arb against a
//            burst-level reference model.
// Revision : 1.0
// ============================================================================
module tb_capi_put_req_arb;

    localparam int EA  = 65;
    localparam int SID = 2;
    localparam int N   = 4;
    localparam int TW  = 5;
    localparam int NT  = 1 << TW;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      i_req_v;
    logic [N*EA-1:0]   i_req_ea;
    logic [N*SID-1:0]  i_req_sid;
    logic [N-1:0]      i_req_data_v;
    logic [N-1:0]      i_req_data_e;
    logic [N*4-1:0]    i_req_data_c;
    logic [N-1:0]      o_req_data_r;
    logic [N-1:0]      o_req_done;
    logic              o_addr_v;
    logic [EA-1:0]     o_addr_ea;
    logic              o_data_v;
    logic              o_data_e;
    logic [3:0]        o_data_c;
    logic [TW-1:0]     o_cmd_tag;
    logic [SID-1:0]    o_sid;
    logic              i_data_r;
    logic              i_rsp_v;
    logic [TW-1:0]     i_rsp_tag;
    logic [TW:0]       o_tags_free;
    logic              o_tag_err;

    capi_put_req_arb #(
        .EA_WIDTH (EA),
        .SID_WIDTH(SID),
        .NREQ     (N),
        .TAG_WIDTH(TW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_req_v     (i_req_v),
        .i_req_ea    (i_req_ea),
        .i_req_sid   (i_req_sid),
        .i_req_data_v(i_req_data_v),
        .i_req_data_e(i_req_data_e),
        .i_req_data_c(i_req_data_c),
        .o_req_data_r(o_req_data_r),
        .o_req_done  (o_req_done),
        .o_addr_v    (o_addr_v),
        .o_addr_ea   (o_addr_ea),
        .o_data_v    (o_data_v),
        .o_data_e    (o_data_e),
        .o_data_c    (o_data_c),
        .o_cmd_tag   (o_cmd_tag),
        .o_sid       (o_sid),
        .i_data_r    (i_data_r),
        .i_rsp_v     (i_rsp_v),
        .i_rsp_tag   (i_rsp_tag),
        .o_tags_free (o_tags_free),
        .o_tag_err   (o_tag_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Per-requester stimulus sources
    logic [EA-1:0]  ea_arr  [N];
    logic [SID-1:0] sid_arr [N];
    logic [3:0]     c_arr   [N];
    int             s_sent  [N];
    int             s_len   [N];

    // Reference model: which requester owns the encoder, beats moved so far,
    // and the set of tags currently out on the bus.
    int             m_owner;
    int             m_rr;
    int             m_beats;
    int             m_tag;
    logic [EA-1:0]  m_ea;
    logic [SID-1:0] m_sid;
    bit   [NT-1:0]  m_busy;
    bit             m_err;

    bit             seen_addr;
    logic [TW-1:0]  seen_tag;

    task automatic model_reset();
        m_owner = -1;
        m_rr    = 0;
        m_beats = 0;
        m_tag   = 0;
        m_busy  = '0;
        m_err   = 1'b0;
        for (int r = 0; r < N; r++) s_sent[r] = 0;
    endtask

    function automatic int free_count();
        int n = 0;
        for (int t = 0; t < NT; t++) if (!m_busy[t]) n++;
        return n;
    endfunction

    task automatic step(input bit rst, input bit rsp_v, input logic [TW-1:0] rsp_tag);
        bit           xfer, acc, endacc, alloc;
        int           g, low, newg;
        logic [N-1:0] e_rdy, e_done;
        @(negedge clk);
        reset     = rst;
        i_rsp_v   = rsp_v;
        i_rsp_tag = rsp_tag;
        for (int r = 0; r < N; r++) begin
            i_req_v[r]      = ($urandom_range(0, 9) < 7);
            i_req_data_v[r] = ($urandom_range(0, 9) < 8);
            i_req_data_e[r] = (s_sent[r] == s_len[r]);
            ea_arr[r]       = EA'({$urandom(), $urandom(), $urandom()});
            sid_arr[r]      = SID'($urandom());
            c_arr[r]        = 4'($urandom());
            i_req_ea[(N-1-r)*EA +: EA]    = ea_arr[r];
            i_req_sid[(N-1-r)*SID +: SID] = sid_arr[r];
            i_req_data_c[(N-1-r)*4 +: 4]  = c_arr[r];
        end
        i_data_r = ($urandom_range(0, 3) != 0);
        #1;
        xfer   = (m_owner >= 0);
        g      = xfer ? m_owner : 0;
        acc    = xfer && i_req_data_v[g] && i_data_r;
        endacc = acc && i_req_data_e[g];
        e_rdy  = '0;
        e_done = '0;
        if (xfer) begin
            e_rdy[g]  = i_data_r;
            e_done[g] = endacc;
        end
        check_eq("addr_v", 128'(o_addr_v), 128'(xfer && m_beats == 0));
        check_eq("data_v", 128'(o_data_v), 128'(xfer && i_req_data_v[g]));
        check_eq("req_data_r", 128'(o_req_data_r), 128'(e_rdy));
        check_eq("req_done", 128'(o_req_done), 128'(e_done));
        check_eq("tags_free", 128'(o_tags_free), 128'(free_count()));
        check_eq("tag_err", 128'(o_tag_err), 128'(m_err));
        if (xfer) begin
            check_eq("data_e", 128'(o_data_e), 128'(i_req_data_e[g]));
            check_eq("data_c", 128'(o_data_c), 128'(c_arr[g]));
            check_eq("addr_ea", 128'(o_addr_ea), 128'(m_ea));
            check_eq("sid", 128'(o_sid), 128'(m_sid));
            check_eq("cmd_tag", 128'(o_cmd_tag), 128'(m_tag));
        end
        if (o_addr_v && !seen_addr) begin
            seen_addr = 1'b1;
            seen_tag  = o_cmd_tag;
        end

        if (rst) begin
            model_reset();
        end else begin
            low = -1;
            for (int t = NT - 1; t >= 0; t--) if (!m_busy[t]) low = t;
            alloc = 1'b0;
            newg  = -1;
            if (!xfer && i_req_v != '0 && free_count() > 0) begin
                for (int k = N - 1; k >= 0; k--) if (i_req_v[(m_rr + k) % N]) newg = (m_rr + k) % N;
                alloc = 1'b1;
            end
            if (alloc) begin
                m_owner = newg;
                m_tag   = low;
                m_ea    = ea_arr[newg];
                m_sid   = sid_arr[newg];
                m_beats = 0;
            end else if (acc) begin
                m_beats++;
                if (endacc) begin
                    m_rr    = (g + 1) % N;
                    m_owner = -1;
                end
            end
            if (rsp_v) begin
                if (m_busy[rsp_tag]) m_busy[rsp_tag] = 1'b0;
                else m_err = 1'b1;
            end
            if (alloc) m_busy[low] = 1'b1;
            if (acc) begin
                if (endacc) begin
                    s_sent[g] = 0;
                    s_len[g]  = $urandom_range(0, 3);
                end else begin
                    s_sent[g]++;
                end
            end
        end
    endtask

    task automatic random_steps(input int n, input int rst_odds);
        bit            rv;
        logic [TW-1:0] rt;
        int            start;
        for (int i = 0; i < n; i++) begin
            rv    = 1'b0;
            rt    = '0;
            start = $urandom_range(0, NT - 1);
            if ($urandom_range(0, 9) < 3) begin
                for (int j = NT - 1; j >= 0; j--) begin
                    if (m_busy[(start + j) % NT]) begin
                        rv = 1'b1;
                        rt = TW'((start + j) % NT);
                    end
                end
            end
            step((rst_odds > 0) && ($urandom_range(0, rst_odds - 1) == 0), rv, rt);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        i_req_v      = '0;
        i_req_ea     = '0;
        i_req_sid    = '0;
        i_req_data_v = '0;
        i_req_data_e = '0;
        i_req_data_c = '0;
        i_data_r     = 1'b0;
        i_rsp_v      = 1'b0;
        i_rsp_tag    = '0;
        seen_addr    = 1'b0;
        seen_tag     = '1;
        for (int r = 0; r < N; r++) s_len[r] = $urandom_range(0, 3);
        repeat (3) @(posedge clk);
        model_reset();

        // Mixed traffic with responses, backpressure and occasional resets
        random_steps(2500, 300);

        // Drain the pool: no responses at all
        step(1'b1, 1'b0, '0);
        random_steps(0, 0);
        for (int i = 0; i < 600; i++) step(1'b0, 1'b0, '0);
        @(posedge clk);
        #1;
        check_eq("pool_drained", 128'(o_tags_free), 128'(0));
        check_eq("stalled_no_addr", 128'(o_addr_v), 128'(0));

        // Free tag 7; the next burst must reuse it
        step(1'b0, 1'b1, TW'(7));
        seen_addr = 1'b0;
        seen_tag  = '1;
        for (int i = 0; i < 100 && !seen_addr; i++) step(1'b0, 1'b0, '0);
        check_eq("tag7_reuse", 128'(seen_tag), 128'(7));

        // Response for a tag that is free sets the sticky error
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, TW'(12));
        @(posedge clk);
        #1;
        check_eq("tag_err_set", 128'(o_tag_err), 128'(1));
        random_steps(300, 0);
        check_eq("tag_err_sticky", 128'(o_tag_err), 128'(1));

        // Reset in the middle of a burst
        for (int i = 0; i < 100 && m_owner < 0; i++) random_steps(1, 0);
        check_eq("burst_active", 128'(m_owner >= 0 && o_data_v !== 1'bx), 128'(1));
        step(1'b1, 1'b0, '0);
        @(posedge clk);
        #1;
        check_eq("rst_tags_free", 128'(o_tags_free), 128'(NT));
        check_eq("rst_data_v", 128'(o_data_v), 128'(0));
        check_eq("rst_tag_err", 128'(o_tag_err), 128'(0));
        check_eq("rst_addr_v", 128'(o_addr_v), 128'(0));
        random_steps(400, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/capi_put_req_arb.md
Name: capi_put_req_arb

Overview:
- Shares one put-command encoder among nreq independent write streams.
- Grants one requester at a time, round-robin, and locks the grant from first beat through the end beat (data_v & data_e accepted).
- Allocates a command tag per burst from a 2**tag_width free pool; tags return on command response.
- Sits between the AFU write engines and the encoder's i_addr_*/i_data_*/i_cmd_tag inputs.

Parameters:
ea_width, 65, effective address width incl. parity bit (matches encoder)
sid_width, 2, stream id width
nreq, 4, number of requesters (2..8)
tag_width, 5, tag width; pool size 2**tag_width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
i_req_v  in  nreq  requester r has burst pending (address valid)
i_req_ea  in  nreq*ea_width  per-requester start EA, requester 0 in MSBs
i_req_sid  in  nreq*sid_width  per-requester stream id
i_req_data_v  in  nreq  per-requester data beat valid
i_req_data_e  in  nreq  per-requester end beat (no payload)
i_req_data_c  in  nreq*4  per-requester count; valid with _e; 0 = 16
o_req_data_r  out  nreq  beat accepted from requester r
o_req_done  out  nreq  one-cycle pulse when r's end beat is accepted
o_addr_v  out  1  to encoder: start address valid
o_addr_ea  out  ea_width  to encoder: granted EA
o_data_v  out  1  to encoder: beat valid
o_data_e  out  1  to encoder: end beat
o_data_c  out  4  to encoder: count
o_cmd_tag  out  tag_width  tag of current burst
o_sid  out  sid_width  sid of current burst
i_data_r  in  1  encoder ready
i_rsp_v  in  1  command response valid, frees tag
i_rsp_tag  in  tag_width  tag being freed
o_tags_free  out  tag_width+1  count of free tags
o_tag_err  out  1  sticky: response for tag not in use

Behaviour:
- Reset: FSM=IDLE; all tags free; o_tags_free=2**tag_width; rr pointer=0 (requester 0 highest priority first); o_tag_err=0; all valid/ready/done outputs 0. Reset mid-burst drops the burst and frees all tags.
- FSM IDLE:
  - If any i_req_v and o_tags_free!=0: pick first requester at or after rr pointer, wrapping.
  - Register grant index, lowest-numbered free tag, EA and sid. Mark tag busy. Go to XFER next cycle.
  - Arbitration latency: 1 cycle.
  - If no tag is free, hold in IDLE.
- FSM XFER:
  - o_addr_v=1 from grant until the first beat is accepted (i_data_r & o_data_v), then 0.
  - o_addr_ea/o_sid/o_cmd_tag held constant for the whole burst.
  - o_data_v/_e/_c = granted requester's signals, combinational mux.
  - o_req_data_r[g] = i_data_r, AND-ed with XFER and grant; other bits 0.
  - Beat with i_data_r=0 is not consumed; all outputs hold.
  - End beat accepted (o_data_v & o_data_e & i_data_r): pulse o_req_done[g]; rr pointer = g+1 mod nreq; go to IDLE.
  - Back-to-back bursts therefore have 1 idle cycle.
- Requester dropping i_req_v while granted is ignored; the grant holds until the end beat.
- Tag pool: busy bit vector.
  - On i_rsp_v, clear the bit next cycle. If the bit was already clear, set o_tag_err; bit stays clear.
  - Allocation and free in the same cycle: both apply. The freed tag is not allocatable until the following cycle.
  - o_tags_free is registered: +1 on free, -1 on alloc, unchanged when both occur.
- Zero-length burst (first beat is an end beat) is legal: addr_v and the end beat go together, tag still consumed.

Test Plan:
- Single requester: r1 req EA=0x1000, 3 beats then end beat (c=0), i_data_r=1. Expect grant 1 cycle after req, o_cmd_tag=0, o_addr_v only with beat 1, o_req_done[1] on end beat, o_tags_free 32->31.
- Round-robin: all 4 requesters request continuously, 1-beat bursts. Grant order 0,1,2,3,0 with one idle cycle between bursts; tags 0..4 allocated in order.
- Backpressure: i_data_r=0 for 5 cycles mid-burst. Outputs are stable, no o_req_data_r, beat count unchanged; burst resumes when ready returns.
- Tag exhaustion: 32 bursts with no responses. The 33rd request stalls in IDLE. i_rsp_tag=7 unblocks it, and the next burst gets tag 7.
- Tag error: i_rsp_v with a free tag 12 sets o_tag_err=1; the flag stays set until reset, and o_tags_free is unchanged.
- Reset mid-burst: assert reset during XFER. Next cycle shows IDLE, o_tags_free=32, o_data_v=0, and the rr pointer has returned to 0.
